// File: rtl/delay_timer.sv
// delay_timer: counts delay_val ticks of CLKS_PER_TICK clocks, one-shot or periodic
// Optional feature macro: DELAY_TIMER_PAUSE_EN adds input delay_pause (freezes counting in HOLD).
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   delay_en        level request: start on rise, abort on fall
//   delay_mode      0 = one-shot, 1 = periodic (sampled at start)
//   delay_val       delay in ticks (sampled at start)
//   delay_pause     freeze counting while high (only with DELAY_TIMER_PAUSE_EN)
//   delay_fin       completion indication
//   delay_busy      high while counting
//   delay_remaining ticks left in HOLD, 0 otherwise
module delay_timer #(
    parameter int CLKS_PER_TICK = 100000,
    parameter int PRESCALE_W    = 17,
    parameter int CNT_W         = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             delay_en,
    input  logic             delay_mode,
    input  logic [CNT_W-1:0] delay_val,
`ifdef DELAY_TIMER_PAUSE_EN
    input  logic             delay_pause,
`endif
    output logic             delay_fin,
    output logic             delay_busy,
    output logic [CNT_W-1:0] delay_remaining
);
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, DONE = 2'd2} state_t;
    localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(CLKS_PER_TICK - 1);
    state_t                state_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [CNT_W-1:0]      ticks_q;
    logic [CNT_W-1:0]      target_q;
    logic                  mode_q;
    logic                  pause;
`ifdef DELAY_TIMER_PAUSE_EN
    assign pause = delay_pause;
`else
    assign pause = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prescale_q <= '0;
            ticks_q    <= '0;
            target_q   <= '0;
            mode_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (delay_en) begin
                    target_q   <= delay_val;
                    mode_q     <= delay_mode;
                    prescale_q <= '0;
                    ticks_q    <= '0;
                    state_q    <= HOLD;
                end
                HOLD: if (!delay_en) begin
                    state_q    <= IDLE;
                    prescale_q <= '0;
                    ticks_q    <= '0;
                end else if (!pause) begin
                    // completion is checked before counting, so ticks never passes target
                    if (ticks_q == target_q) state_q <= DONE;
                    else if (prescale_q == PS_LAST) begin
                        prescale_q <= '0;
                        ticks_q    <= ticks_q + CNT_W'(1);
                    end else prescale_q <= prescale_q + PRESCALE_W'(1);
                end
                DONE: if (!delay_en) state_q <= IDLE;
                else if (mode_q) begin
                    state_q    <= HOLD;
                    prescale_q <= '0;
                    ticks_q    <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign delay_fin       = (state_q == DONE) & delay_en;
    assign delay_busy      = state_q == HOLD;
    assign delay_remaining = (state_q == HOLD) ? target_q - ticks_q : '0;
endmodule
